// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the ALU execution controller: FSM states,
// instruction field positions, flag bit positions and ALU mode codes.
package alu_exec_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  // Instruction word layout
  localparam int INSTR_W     = 16;
  localparam int USE_REG_BIT = 15;
  localparam int WR_REG_BIT  = 14;
  localparam int IDX_HI      = 13;
  localparam int IDX_LO      = 12;
  localparam int MODE_HI     = 11;
  localparam int MODE_LO     = 8;
  localparam int IMM_HI      = 7;
  localparam int IMM_LO      = 0;

  // Flag register layout {Z,C,S,O}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 0;

  // ALU mode codes; the operation behind each code lives in the external ALU
  typedef logic [3:0] alu_mode_t;
  localparam alu_mode_t ALU_ADD  = 4'b0000;
  localparam alu_mode_t ALU_SUB  = 4'b0001;
  localparam alu_mode_t ALU_LD   = 4'b0010;
  localparam alu_mode_t ALU_MOVA = 4'b0011;
  localparam alu_mode_t ALU_AND  = 4'b0100;
  localparam alu_mode_t ALU_OR   = 4'b0101;
  localparam alu_mode_t ALU_XOR  = 4'b0110;
  localparam alu_mode_t ALU_ADC  = 4'b0111;
  localparam alu_mode_t ALU_SHL  = 4'b1000;
  localparam alu_mode_t ALU_SHR  = 4'b1001;
  localparam alu_mode_t ALU_NOT  = 4'b1010;
  localparam alu_mode_t ALU_NAND = 4'b1011;
  localparam alu_mode_t ALU_NOR  = 4'b1100;
  localparam alu_mode_t ALU_XNOR = 4'b1101;
  localparam alu_mode_t ALU_CLR  = 4'b1110;
  localparam alu_mode_t ALU_SBC  = 4'b1111;

  // Only arithmetic and shift modes produce a meaningful carry
  function automatic logic mode_updates_carry(input alu_mode_t m);
    return (m == ALU_ADD) || (m == ALU_SUB) || (m == ALU_ADC) ||
           (m == ALU_SHL) || (m == ALU_SHR) || (m == ALU_SBC);
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_regfile.sv
// 4 x 8-bit general register file: one combinational read port,
// one synchronous write port, synchronous reset to zero.
module regfile4x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rd_idx_i,
  output logic [7:0] rd_data_o,
  input  logic       we_i,
  input  logic [1:0] wr_idx_i,
  input  logic [7:0] wr_data_i
);

  logic [3:0][7:0] regs_w;

  for (genvar gi = 0; gi < 4; gi++) begin : g_reg
    logic [7:0] data_q;

    // Each register clears on reset and loads when addressed by a write
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
      end else if (we_i && (wr_idx_i == 2'(gi))) begin
        data_q <= wr_data_i;
      end
    end

    assign regs_w[gi] = data_q;
  end

  assign rd_data_o = regs_w[rd_idx_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequencer that feeds an external ALU: accepts one instruction, fetches
// operand1 from imm or the register file, runs one ALU cycle and writes the
// result back to ACC or a register, updating the flag register.
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  input  logic [15:0]  instr,
  output logic         instr_ready,
  output logic [7:0]   alu_op1,
  output logic [7:0]   alu_op2,
  output logic [3:0]   alu_mode,
  output logic         alu_e,
  output logic [3:0]   alu_rflags,
  input  logic [7:0]   alu_out,
  input  logic [3:0]   alu_wflags,
  output logic [7:0]   acc,
  output logic [3:0]   flags,
  output logic         busy,
  output logic         done
);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q;
  logic [7:0]           op1_q;
  logic [7:0]           res_q;
  logic [3:0]           wflags_q;
  logic [7:0]           acc_q;
  logic [3:0]           flags_q;

  logic                 use_reg;
  logic                 wr_reg;
  logic [1:0]           idx;
  alu_mode_t            mode;
  logic [7:0]           imm;
  logic [7:0]           rf_rd_data;
  logic                 rf_we;

  assign use_reg = instr_q[USE_REG_BIT];
  assign wr_reg  = instr_q[WR_REG_BIT];
  assign idx     = instr_q[IDX_HI:IDX_LO];
  assign mode    = instr_q[MODE_HI:MODE_LO];
  assign imm     = instr_q[IMM_HI:IMM_LO];

  // The FSM never lets a DECODE read and a WB write coincide, so no bypass
  assign rf_we = (state_q == ST_WB) && wr_reg;

  regfile4x8 u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_idx_i  (idx),
    .rd_data_o (rf_rd_data),
    .we_i      (rf_we),
    .wr_idx_i  (idx),
    .wr_data_i (res_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control outputs; only IDLE waits for input
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    busy        = 1'b1;
    alu_e       = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        alu_e   = 1'b1;
        state_d = ST_WB;
      end
      ST_WB: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath latches: instruction, operand1, ALU result, ACC and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= '0;
      op1_q    <= '0;
      res_q    <= '0;
      wflags_q <= '0;
      acc_q    <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) instr_q <= instr;
        end
        ST_DECODE: begin
          op1_q <= use_reg ? rf_rd_data : imm;
        end
        ST_EXEC: begin
          res_q    <= alu_out;
          wflags_q <= alu_wflags;
        end
        ST_WB: begin
          if (!wr_reg) acc_q <= res_q;
          flags_q[FLAG_Z] <= wflags_q[FLAG_Z];
          flags_q[FLAG_S] <= wflags_q[FLAG_S];
          flags_q[FLAG_O] <= wflags_q[FLAG_O];
          if (mode_updates_carry(mode)) flags_q[FLAG_C] <= wflags_q[FLAG_C];
        end
        default: ;
      endcase
    end
  end

  assign alu_op1    = op1_q;
  assign alu_op2    = acc_q;
  assign alu_mode   = mode;
  assign alu_rflags = flags_q;
  assign acc        = acc_q;
  assign flags      = flags_q;

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port instr_valid, input, 1, instruction offered.
REQ-004 SHALL have port instr, input, 16, instruction word:
- [15] use_reg: operand1 comes from R[idx], not imm.
- [14] wr_reg: result goes to R[idx], not ACC.
- [13:12] idx.
- [11:8] mode.
- [7:0] imm.
REQ-005 SHALL have port instr_ready, output, 1, high only in IDLE.
REQ-006 SHALL have port alu_op1, output, 8, ALU operand1.
REQ-007 SHALL have port alu_op2, output, 8, ALU operand2; always equals ACC.
REQ-008 SHALL have port alu_mode, output, 4, ALU mode.
REQ-009 SHALL have port alu_e, output, 1, ALU enable.
REQ-010 SHALL have port alu_rflags, output, 4, current flag register.
REQ-011 SHALL have port alu_out, input, 8, ALU result.
REQ-012 SHALL have port alu_wflags, input, 4, ALU flags {Z,C,S,O}.
REQ-013 SHALL have port acc, output, 8, accumulator value.
REQ-014 SHALL have port flags, output, 4, flag register {Z,C,S,O}.
REQ-015 SHALL have port busy, output, 1, high when not in IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-017 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-018 SHALL implement FSM IDLE->DECODE->EXEC->WB->IDLE; every non-IDLE state advances unconditionally.
REQ-019 SHALL accept an instruction on the edge where state=IDLE and instr_valid=1, latching instr into an internal instruction register; instr changes while busy SHALL have no effect.
REQ-020 SHALL in DECODE latch operand1 = use_reg ? R[idx] : imm.
REQ-021 SHALL in EXEC drive alu_e=1, alu_mode=latched mode, and alu_op1=operand1 latch, and register alu_out and alu_wflags at the end of EXEC; alu_e SHALL be 0 in all other states.
REQ-022 SHALL in WB assert done=1 and write the registered result to R[idx] if wr_reg, else to ACC; the write SHALL be visible the cycle after WB.
REQ-023 SHALL in WB update flag bits as follows:
- Z, S, O: always updated.
- C: updated only for modes 0000, 0001, 0111, 1000, 1001, 1111; held otherwise.
REQ-024 SHALL give a latency of 4 cycles from accept to IDLE, and a maximum throughput of 1 instruction per 4 cycles.
REQ-025 SHALL drive alu_rflags = flags at all times.
REQ-026 SHALL treat a write to R[idx] and a read of the same R[idx] in DECODE as impossible, because the FSM serialises them; no bypass is required.

Reset
REQ-027 SHALL on rst=1 at any edge, including mid-operation, set:
- state=IDLE.
- ACC=0x00.
- R0..R3=0x00.
- flags=4'b0000.
- done=0.
- busy=0.
- Instruction and operand latches=0.
REQ-028 SHALL discard an in-flight instruction on reset, with no write and no done.
REQ-029 SHALL take rst precedence over instr_valid in the same cycle.

Structure
REQ-030 SHALL place the ALU mode constants (0000..1111), the FSM state encoding and the instruction field positions in a shared package.
REQ-031 SHALL implement the 4x8 register file as sub-module regfile4x8, with one combinational read port, one write port and synchronous reset.
REQ-032 SHALL instantiate no ALU; the ALU connects externally through the alu_* ports.

Verification
REQ-033 SHALL cover load: after reset, instr=0x02F0 (mode 0010, imm F0) -> after WB, acc=0xF0, flags=4'b0010, done pulses once exactly 3 cycles after the accept edge.
REQ-034 SHALL cover add with carry: then instr=0x0020 (mode 0000, imm 20) -> acc=0x10, flags=4'b0100.
REQ-035 SHALL cover carry hold: then instr=0x0400 (AND, imm 00) -> acc=0x00, flags=4'b1100.
REQ-036 SHALL cover register path: instr=0x625A (wr_reg, idx2, mode 0010, imm 5A) -> R2=0x5A, acc unchanged; then with acc=0x10, instr=0xA600 (use_reg, idx2, XOR) -> acc=0x4A.
REQ-037 SHALL cover reset mid-op: rst asserted during EXEC -> next cycle state=IDLE, acc=0x00, flags=0, instr_ready=1, no done pulse.
REQ-038 SHALL cover busy hold: instr_valid held high with changing instr during DECODE..WB -> only the first instruction executes, and instr_ready stays 0 until IDLE.
